// File: rtl/bank_fifo_pkg.sv
// Shared types and default sizes for the BankFifo write arbiter and read-side controller.
package bank_fifo_pkg;

   localparam int unsigned WORD_WIDTH_DEF = 16;
   localparam int unsigned BURST_LEN_DEF  = 128;

   typedef enum logic {
      Idle  = 1'b0,
      Grant = 1'b1
   } arb_state_e;

endpackage : bank_fifo_pkg

// File: rtl/bank_fifo_rr_pick.sv
// Combinational round-robin picker: first active request after 'last', wrapping.
module bank_fifo_rr_pick
   import bank_fifo_pkg::*;
#(
   parameter int unsigned NumReq = 2,
   parameter int unsigned IdxW   = $clog2(NumReq)
) (
   input  logic [NumReq-1:0] req,
   input  logic [IdxW-1:0]   last,
   output logic              any,
   output logic [IdxW-1:0]   idx
);

   int unsigned cand;

   // Scan last+1 .. last+NumReq (mod NumReq); first hit wins, 'last' itself has lowest priority.
   always_comb begin
      any  = 1'b0;
      idx  = '0;
      cand = 0;
      for (int unsigned k = 1; k <= NumReq; k++) begin
         cand = (32'(last) + k) % NumReq;
         if (!any && req[IdxW'(cand)]) begin
            any = 1'b1;
            idx = IdxW'(cand);
         end
      end
   end

endmodule : bank_fifo_rr_pick

// File: rtl/bank_fifo_write_arb.sv
// Round-robin arbiter sharing one BankFifo write port among NumReq producers, one burst per grant.
module bank_fifo_write_arb
   import bank_fifo_pkg::*;
#(
   parameter int unsigned NumReq    = 2,
   parameter int unsigned WordWidth = WORD_WIDTH_DEF,
   parameter int unsigned BurstLen  = BURST_LEN_DEF
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NumReq-1:0]             req_trigger,
   input  logic [NumReq*WordWidth-1:0]   req_data,
   output logic [NumReq-1:0]             req_done,
   output logic                          fifo_trigger,
   output logic [WordWidth-1:0]          fifo_data,
   input  logic                          fifo_done,
   output logic                          grant_valid,
   output logic [$clog2(NumReq)-1:0]     grant_idx
);

   localparam int unsigned IdxW = $clog2(NumReq);
   localparam int unsigned CntW = $clog2(BurstLen);
   localparam logic [CntW-1:0] CntLast = CntW'(BurstLen - 1);
   localparam logic [IdxW-1:0] LastRst = IdxW'(NumReq - 1);

   arb_state_e        state_q, state_d;
   logic [IdxW-1:0]   owner_q, owner_d;
   logic [IdxW-1:0]   last_q,  last_d;
   logic [CntW-1:0]   count_q, count_d;

   logic              pick_any;
   logic [IdxW-1:0]   pick_idx;
   logic              owner_trig;
   logic [WordWidth-1:0] owner_data;
   logic [WordWidth-1:0] data_arr [NumReq];

   // Unpack the flat requester data bus so the owner can be selected by index.
   for (genvar g = 0; g < NumReq; g++) begin : g_unpack
      assign data_arr[g] = req_data[g*WordWidth +: WordWidth];
   end

   assign owner_trig = req_trigger[owner_q];
   assign owner_data = data_arr[owner_q];

   bank_fifo_rr_pick #(
      .NumReq (NumReq),
      .IdxW   (IdxW)
   ) u_pick (
      .req  (req_trigger),
      .last (last_q),
      .any  (pick_any),
      .idx  (pick_idx)
   );

   // State and arbitration registers; reset gives requester 0 first priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= Idle;
         owner_q <= '0;
         last_q  <= LastRst;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         count_q <= count_d;
      end
   end

   // Next state: grant on any request, release on full burst or owner yield.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      count_d = count_q;
      unique case (state_q)
         Idle: begin
            if (pick_any) begin
               owner_d = pick_idx;
               count_d = '0;
               state_d = Grant;
            end
         end
         Grant: begin
            if (!owner_trig) begin
               last_d  = owner_q;
               state_d = Idle;
            end else if (fifo_done) begin
               if (count_q == CntLast) begin
                  last_d  = owner_q;
                  state_d = Idle;
               end else begin
                  count_d = count_q + CntW'(1);
               end
            end
         end
         default: state_d = Idle;
      endcase
   end

   // Route the owner's trigger/data to the FIFO and the FIFO's done back to the owner only.
   always_comb begin
      fifo_trigger = 1'b0;
      fifo_data    = '0;
      req_done     = '0;
      grant_valid  = 1'b0;
      grant_idx    = '0;
      if (state_q == Grant) begin
         fifo_trigger       = owner_trig;
         fifo_data          = owner_data;
         req_done[owner_q]  = fifo_done;
         grant_valid        = 1'b1;
         grant_idx          = owner_q;
      end
   end

`ifdef SIM
   // A FIFO acknowledge with no grant outstanding means the FIFO side broke protocol.
   always @(posedge clk) begin
      if (rst_n && state_q == Idle) begin
         assert (!fifo_done) else $error("fifo_done asserted while arbiter Idle");
      end
   end
`endif

endmodule : bank_fifo_write_arb

// File: tb/tb_bank_fifo_write_arb.sv
// Directed bench for bank_fifo_write_arb with a 3-requester instance and an ideal FIFO model.
module tb_bank_fifo_write_arb;

   localparam int unsigned NR = 3;
   localparam int unsigned WW = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NR-1:0]     trig;
   logic [NR*WW-1:0]  rdata;
   logic [NR-1:0]     done;
   logic              ftrig;
   logic [WW-1:0]     fdata;
   logic              fdone;
   logic              gv;
   logic [1:0]        gidx;
   logic              full;

   int                n_cmp;
   int                n_bad;
   logic [11:0]       seq [NR];

   logic [22:0]       obs;
   logic [22:0]       exp_v;
   logic              o_gv;
   logic [1:0]        o_idx;
   logic              o_trig;
   logic [NR-1:0]     o_done;
   logic [WW-1:0]     o_data;

   // FIFO model: accepts every triggered word unless the bench marks it full.
   assign fdone = ftrig & ~full;

   always #5 clk = ~clk;

   bank_fifo_write_arb #(
      .NumReq    (NR),
      .WordWidth (WW),
      .BurstLen  (128)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_trigger  (trig),
      .req_data     (rdata),
      .req_done     (done),
      .fifo_trigger (ftrig),
      .fifo_data    (fdata),
      .fifo_done    (fdone),
      .grant_valid  (gv),
      .grant_idx    (gidx)
   );

   // Producers present {index, sequence} tagged words.
   task automatic drive_data();
      for (int i = 0; i < NR; i++) rdata[i*WW +: WW] = {4'(i), seq[i]};
   endtask

   // Sample outputs mid-cycle, then advance past the edge and let acknowledged producers step.
   task automatic cycle();
      @(negedge clk);
      o_gv   = gv;
      o_idx  = gidx;
      o_trig = ftrig;
      o_done = done;
      o_data = fdata;
      obs    = {gv, gidx, ftrig, done, fdata};
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) if (o_done[i]) seq[i] = seq[i] + 12'd1;
      drive_data();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      trig  = '0;
      full  = 1'b0;
      for (int i = 0; i < NR; i++) seq[i] = '0;
      drive_data();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      trig  = 3'b111;
      full  = 1'b0;
      for (int i = 0; i < NR; i++) seq[i] = '0;
      drive_data();
      #2;
      n_cmp++;
      if ({gv, gidx, ftrig, done, fdata} !== 23'd0) begin
         n_bad++;
         $display("FAIL reset_outputs got %h exp %h", {gv, gidx, ftrig, done, fdata}, 23'd0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      n_cmp++;
      if ({gv, gidx, ftrig, done, fdata} !== 23'd0) begin
         n_bad++;
         $display("FAIL reset_release got %h exp %h", {gv, gidx, ftrig, done, fdata}, 23'd0);
      end
      cycle();
      n_cmp++;
      if (obs !== 23'd0) begin
         n_bad++;
         $display("FAIL reset_idle got %h exp %h", obs, 23'd0);
      end
      cycle();
      exp_v = {1'b1, 2'd0, 1'b1, 3'b001, 16'h0000};
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL reset_first_winner got %h exp %h", obs, exp_v);
      end
      trig = '0;
   endtask

   task automatic test_single();
      do_reset();
      trig = 3'b001;
      cycle();
      n_cmp++;
      if (obs !== 23'd0) begin
         n_bad++;
         $display("FAIL single_idle got %h exp %h", obs, 23'd0);
      end
      for (int k = 0; k < 128; k++) begin
         cycle();
         exp_v = {1'b1, 2'd0, 1'b1, 3'b001, 16'(k)};
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL single_word k=%0d got %h exp %h", k, obs, exp_v);
         end
      end
      cycle();
      n_cmp++;
      if (obs !== 23'd0) begin
         n_bad++;
         $display("FAIL single_gap got %h exp %h", obs, 23'd0);
      end
      cycle();
      exp_v = {1'b1, 2'd0, 1'b1, 3'b001, 16'h0080};
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL single_regrant got %h exp %h", obs, exp_v);
      end
      trig = '0;
   endtask

   task automatic test_round_robin();
      int own;
      do_reset();
      trig = 3'b011;
      cycle();
      n_cmp++;
      if (obs !== 23'd0) begin
         n_bad++;
         $display("FAIL rr_idle got %h exp %h", obs, 23'd0);
      end
      for (int b = 0; b < 4; b++) begin
         own = b % 2;
         for (int k = 0; k < 128; k++) begin
            cycle();
            exp_v = {1'b1, 2'(own), 1'b1, 3'(1 << own), 4'(own), 12'((b / 2) * 128 + k)};
            n_cmp++;
            if (obs !== exp_v) begin
               n_bad++;
               $display("FAIL rr_word b=%0d k=%0d got %h exp %h", b, k, obs, exp_v);
            end
         end
         cycle();
         n_cmp++;
         if (obs !== 23'd0) begin
            n_bad++;
            $display("FAIL rr_gap b=%0d got %h exp %h", b, obs, 23'd0);
         end
      end
      trig = '0;
   endtask

   task automatic test_yield();
      do_reset();
      trig = 3'b010;
      cycle();
      n_cmp++;
      if (obs !== 23'd0) begin
         n_bad++;
         $display("FAIL yield_idle0 got %h exp %h", obs, 23'd0);
      end
      for (int k = 0; k < 5; k++) begin
         cycle();
         exp_v = {1'b1, 2'd1, 1'b1, 3'b010, 16'h1000 + 16'(k)};
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL yield_word k=%0d got %h exp %h", k, obs, exp_v);
         end
      end
      trig = 3'b001;
      cycle();
      exp_v = {1'b1, 2'd1, 1'b0, 3'b000, 16'h1005};
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL yield_release got %h exp %h", obs, exp_v);
      end
      cycle();
      n_cmp++;
      if (obs !== 23'd0) begin
         n_bad++;
         $display("FAIL yield_idle1 got %h exp %h", obs, 23'd0);
      end
      cycle();
      exp_v = {1'b1, 2'd0, 1'b1, 3'b001, 16'h0000};
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL yield_grant0 got %h exp %h", obs, exp_v);
      end
      trig = 3'b010;
      cycle();
      exp_v = {1'b1, 2'd0, 1'b0, 3'b000, 16'h0001};
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL yield_release0 got %h exp %h", obs, exp_v);
      end
      cycle();
      n_cmp++;
      if (obs !== 23'd0) begin
         n_bad++;
         $display("FAIL yield_idle2 got %h exp %h", obs, 23'd0);
      end
      for (int k = 0; k < 128; k++) begin
         cycle();
         exp_v = {1'b1, 2'd1, 1'b1, 3'b010, 16'h1005 + 16'(k)};
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL yield_regrant_word k=%0d got %h exp %h", k, obs, exp_v);
         end
      end
      cycle();
      n_cmp++;
      if (obs !== 23'd0) begin
         n_bad++;
         $display("FAIL yield_burst_end got %h exp %h", obs, 23'd0);
      end
      trig = '0;
   endtask

   task automatic test_fifo_full();
      do_reset();
      trig = 3'b001;
      cycle();
      n_cmp++;
      if (obs !== 23'd0) begin
         n_bad++;
         $display("FAIL full_idle got %h exp %h", obs, 23'd0);
      end
      for (int k = 0; k < 128; k++) begin
         if (k == 60) begin
            full = 1'b1;
            for (int s = 0; s < 40; s++) begin
               cycle();
               exp_v = {1'b1, 2'd0, 1'b1, 3'b000, 16'd60};
               n_cmp++;
               if (obs !== exp_v) begin
                  n_bad++;
                  $display("FAIL full_stall s=%0d got %h exp %h", s, obs, exp_v);
               end
            end
            full = 1'b0;
         end
         cycle();
         exp_v = {1'b1, 2'd0, 1'b1, 3'b001, 16'(k)};
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL full_word k=%0d got %h exp %h", k, obs, exp_v);
         end
      end
      cycle();
      n_cmp++;
      if (obs !== 23'd0) begin
         n_bad++;
         $display("FAIL full_burst_end got %h exp %h", obs, 23'd0);
      end
      trig = '0;
   endtask

   task automatic test_async_reset();
      do_reset();
      trig = 3'b011;
      cycle();
      for (int k = 0; k < 128; k++) cycle();
      cycle();
      for (int k = 0; k < 30; k++) begin
         cycle();
         exp_v = {1'b1, 2'd1, 1'b1, 3'b010, 16'h1000 + 16'(k)};
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL areset_pre k=%0d got %h exp %h", k, obs, exp_v);
         end
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({gv, gidx, ftrig, done, fdata} !== 23'd0) begin
         n_bad++;
         $display("FAIL areset_live got %h exp %h", {gv, gidx, ftrig, done, fdata}, 23'd0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycle();
      n_cmp++;
      if (obs !== 23'd0) begin
         n_bad++;
         $display("FAIL areset_idle got %h exp %h", obs, 23'd0);
      end
      cycle();
      exp_v = {1'b1, 2'd0, 1'b1, 3'b001, 16'h0080};
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL areset_first got %h exp %h", obs, exp_v);
      end
      trig = '0;
   endtask

   task automatic test_soak();
      logic [11:0]   nxt [NR];
      logic [NR-1:0] e_done;
      logic          e_trig;
      do_reset();
      for (int i = 0; i < NR; i++) nxt[i] = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NR; i++) if ($urandom_range(7) == 0) trig[i] = ~trig[i];
         full = ($urandom_range(3) == 0);
         cycle();
         e_trig = o_gv ? trig[o_idx] : 1'b0;
         e_done = (o_gv && trig[o_idx] && !full) ? NR'(1 << o_idx) : '0;
         n_cmp++;
         if ({o_trig, o_done} !== {e_trig, e_done}) begin
            n_bad++;
            $display("FAIL soak_route c=%0d got %b/%b exp %b/%b", c, o_trig, o_done, e_trig, e_done);
         end
         if (o_done != '0) begin
            n_cmp++;
            if (o_data !== {4'(o_idx), nxt[o_idx]}) begin
               n_bad++;
               $display("FAIL soak_seq c=%0d got %h exp %h", c, o_data, {4'(o_idx), nxt[o_idx]});
            end
            nxt[o_idx] = nxt[o_idx] + 12'd1;
         end
      end
      trig = '0;
      full = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      trig  = '0;
      full  = 1'b0;
      rdata = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_yield();
      test_fifo_full();
      test_async_reset();
      test_soak();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_bank_fifo_write_arb

// File: doc/bank_fifo_write_arb.md
# bank_fifo_write_arb

Single-clock arbiter that shares the write port of one `BankFifo` among `NumReq` producers. Grants the port to one requester at a time in round-robin order, holds the grant for a burst of up to `BurstLen` words (one bank), and routes trigger, data and done between the winner and the FIFO. Sits in the FIFO write-clock domain, between producer blocks and the `BankFifo` `w_*` port.

## Interface
- `NumReq`, 2, number of requesters (2..8)
- `WordWidth`, 16, FIFO word width
- `BurstLen`, 128, maximum words per grant (one bank)
- `clk`  in  1  write-domain clock; drives the FIFO `w_clk`
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_trigger`  in  NumReq  per-requester write request, level
- `req_data`  in  NumReq*WordWidth  requester i data in bits [i*WordWidth +: WordWidth]
- `req_done`  out  NumReq  word from requester i accepted this cycle
- `fifo_trigger`  out  1  to FIFO `w_trigger`
- `fifo_data`  out  WordWidth  to FIFO `w_data`
- `fifo_done`  in  1  from FIFO `w_done`: word accepted this cycle
- `grant_valid`  out  1  a requester owns the port
- `grant_idx`  out  $clog2(NumReq)  current owner (valid when `grant_valid`)

## Operation
- States: `Idle`, `Grant`.
- `Idle`: if any `req_trigger` is high, pick the winner with round-robin priority starting at `last+1` (mod NumReq), latch it as `owner`, clear `count`, go to `Grant`. Otherwise stay.
- `Grant`: `fifo_trigger = req_trigger[owner]`, `fifo_data = req_data[owner]` (combinational muxes), `req_done[owner] = fifo_done`, all other `req_done` bits 0.
- On each `fifo_done` in `Grant`, `count` increments. `count` is $clog2(BurstLen) bits wide, saturating is not needed because release happens at `BurstLen`.
- Release from `Grant` to `Idle`, with `last <= owner`, when either:
  - `fifo_done` and `count == BurstLen-1` (burst complete), or
  - `req_trigger[owner]` is low (owner yielded).
- FIFO full: `fifo_done` stays low, the grant is held and `count` frozen. There is no timeout.
- Outside `Grant`: `fifo_trigger = 0`, `fifo_data = 0`, `req_done = 0`.
- Non-owners are never acknowledged. Their trigger and data are ignored until they win.
- A requester that releases with trigger still high re-arbitrates normally. It wins again only if no other requester is pending.

## Timing
- Reset values: state `Idle`, `owner = 0`, `last = NumReq-1` (requester 0 has first priority), `count = 0`. All outputs 0. Reset takes effect asynchronously and may assert mid-burst. The in-flight word is not acknowledged after reset.
- Grant latency: `req_trigger` high in cycle N while in `Idle` gives `grant_valid` and `fifo_trigger` in N+1.
- Throughput in `Grant`: one word per cycle while the FIFO has space.
- One dead `Idle` cycle follows every release, so the minimum gap between grants is 1 cycle.
- Simultaneous release and new request: the request is seen in the `Idle` cycle and granted the cycle after.
- `fifo_done` is consumed only in `Grant`. A `fifo_done` in `Idle` is ignored and is a protocol error flagged by an `ifdef SIM` assertion.

## Structure
- Shared package `bank_fifo_pkg`: state typedef (`Idle`, `Grant`), default `WordWidth` and `BurstLen` constants, shared with the `BankFifo` read-side controller.
- One sub-module, `bank_fifo_rr_pick`: combinational round-robin picker.
  - Inputs: request vector, `last`.
  - Outputs: `any`, `idx`.
- Top level holds the state register, `owner`/`last`/`count` registers and the output muxes. Target size is about 150–250 lines.

## Test plan
- **Single requester:** req0 high continuously, FIFO never full -> `grant_idx`=0 from cycle 1. 128 consecutive `req_done[0]`, then 1 `Idle` cycle, then regrant to 0. Data 0x0000..0x007F arrives in order.
- **Round-robin:** req0 and req1 both high from reset -> bursts alternate 0,1,0,1. Each burst is 128 words with a 1-cycle gap. `req_done[1]` never fires while `grant_idx`=0.
- **Yield:** req1 drops trigger after 5 accepted words -> release, `Idle` next cycle, then grant to req0. req1's count restarts at 0 on its next grant.
- **FIFO full:** hold `fifo_done` low 40 cycles mid-burst at count 60 -> grant held, `count` stays 60, resumes at 61. The burst still totals 128 words.
- **Async reset mid-burst:** assert `rst_n` low at count 30 between clock edges -> all outputs 0 immediately. After release, requester 0 wins first.
- **Scoreboard soak:** 3 requesters with random trigger patterns tagging data {idx, seq} -> per-requester sequence is gapless and ordered, and no word is duplicated or lost.
